// File: rtl/rng_lfsr_bank.sv
// Multi-channel 32-bit Galois LFSR bank with bounded draws by rejection sampling.
// Optional build macro RNG_FREERUN_EN: LFSRs also step every IDLE cycle.
module rng_lfsr_bank #(
  parameter int          NCH          = 4,
  parameter int          OUT_W        = 4,
  parameter logic [31:0] POLY         = 32'h80200003,
  parameter logic [31:0] SEED_DEFAULT = 32'd758932,
  parameter int          MAX_TRY      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seed_load,
  input  logic [31:0]          seed,
  input  logic                 req,
  input  logic [2:0]           mode,
  input  logic [OUT_W-1:0]     limit,
  output logic                 busy,
  output logic                 valid,
  output logic [NCH*OUT_W-1:0] o,
  output logic [NCH-1:0]       fallback
);

  localparam logic [7:0] LP_MAX_TRY = 8'(MAX_TRY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    CHECK = 2'd2
  } state_t;

  function automatic logic [31:0] f_whiten(input logic [31:0] x, input int c);
    logic [31:0] v;
    v = x ^ (32'(c) * 32'h9E3779B9);
    if (v == 32'h0) begin
      v = 32'h1;
    end else begin
      v = v;
    end
    return v;
  endfunction

  function automatic logic [31:0] f_step(input logic [31:0] s);
    logic [31:0] v;
    if (s[0]) begin
      v = (s >> 1) ^ POLY;
    end else begin
      v = s >> 1;
    end
    return v;
  endfunction

  state_t                 r_state;
  logic [31:0]            r_lfsr [NCH];
  logic [2:0]             r_mode;
  logic [OUT_W-1:0]       r_limit;
  logic [NCH-1:0]         r_acc;
  logic [7:0]             r_tries;
  logic [2:0]             r_steps;
  logic [NCH*OUT_W-1:0]   r_res;
  logic                   r_busy;
  logic                   r_valid;
  logic [NCH*OUT_W-1:0]   r_o;
  logic [NCH-1:0]         r_fallback;

  logic [31:0]            w_step [NCH];
  logic [NCH-1:0]         w_ok;
  logic [NCH-1:0]         w_acc_next;
  logic [NCH*OUT_W-1:0]   w_res_next;
  logic [NCH*OUT_W-1:0]   w_o_next;
  logic [7:0]             w_tries_inc;

  // Per-channel next LFSR value, acceptance test and merged draw results.
  always_comb begin
    w_acc_next  = r_acc;
    w_res_next  = r_res;
    w_o_next    = {(NCH*OUT_W){1'b0}};
    w_ok        = {NCH{1'b0}};
    w_tries_inc = r_tries + 8'd1;
    for (int c = 0; c < NCH; c++) begin
      w_step[c] = f_step(r_lfsr[c]);
      if ((r_limit == {OUT_W{1'b0}}) || (r_lfsr[c][OUT_W-1:0] < r_limit)) begin
        w_ok[c] = 1'b1;
      end else begin
        w_ok[c] = 1'b0;
      end
      if (!r_acc[c] && w_ok[c]) begin
        w_acc_next[c] = 1'b1;
        w_res_next[c*OUT_W +: OUT_W] = r_lfsr[c][OUT_W-1:0];
      end else begin
        w_acc_next[c] = r_acc[c];
      end
      // Channels still unaccepted at the end of a draw report zero.
      if (w_acc_next[c]) begin
        w_o_next[c*OUT_W +: OUT_W] = w_res_next[c*OUT_W +: OUT_W];
      end else begin
        w_o_next[c*OUT_W +: OUT_W] = {OUT_W{1'b0}};
      end
    end
  end

  // Draw FSM, LFSR bank and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        r_lfsr[c] <= f_whiten(SEED_DEFAULT, c);
      end
      r_state    <= IDLE;
      r_mode     <= 3'd0;
      r_limit    <= {OUT_W{1'b0}};
      r_acc      <= {NCH{1'b0}};
      r_tries    <= 8'd0;
      r_steps    <= 3'd0;
      r_res      <= {(NCH*OUT_W){1'b0}};
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_o        <= {(NCH*OUT_W){1'b0}};
      r_fallback <= {NCH{1'b0}};
    end else if (seed_load) begin
      for (int c = 0; c < NCH; c++) begin
        r_lfsr[c] <= f_whiten(seed, c);
      end
      r_state    <= IDLE;
      r_acc      <= {NCH{1'b0}};
      r_tries    <= 8'd0;
      r_steps    <= 3'd0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_o        <= {(NCH*OUT_W){1'b0}};
      r_fallback <= {NCH{1'b0}};
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
`ifdef RNG_FREERUN_EN
          for (int c = 0; c < NCH; c++) begin
            r_lfsr[c] <= w_step[c];
          end
`else
          for (int c = 0; c < NCH; c++) begin
            r_lfsr[c] <= r_lfsr[c];
          end
`endif
          if (req) begin
            r_mode     <= mode;
            r_limit    <= limit;
            r_acc      <= {NCH{1'b0}};
            r_fallback <= {NCH{1'b0}};
            r_tries    <= 8'd0;
            r_steps    <= 3'd0;
            r_busy     <= 1'b1;
            r_state    <= STEP;
          end else begin
            r_state <= IDLE;
          end
        end
        STEP: begin
          for (int c = 0; c < NCH; c++) begin
            if (!r_acc[c]) begin
              r_lfsr[c] <= w_step[c];
            end else begin
              r_lfsr[c] <= r_lfsr[c];
            end
          end
          r_steps <= r_steps + 3'd1;
          if (r_steps == r_mode) begin
            r_state <= CHECK;
          end else begin
            r_state <= STEP;
          end
        end
        CHECK: begin
          r_acc <= w_acc_next;
          r_res <= w_res_next;
          if (&w_acc_next) begin
            r_o        <= w_o_next;
            r_fallback <= {NCH{1'b0}};
            r_valid    <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end else if (w_tries_inc == LP_MAX_TRY) begin
            r_o        <= w_o_next;
            r_fallback <= ~w_acc_next;
            r_valid    <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_tries <= w_tries_inc;
            r_steps <= 3'd0;
            r_state <= STEP;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign valid    = r_valid;
  assign o        = r_o;
  assign fallback = r_fallback;

endmodule

// File: tb/tb_rng_lfsr_bank.sv
// Scoreboarded bench for rng_lfsr_bank: per-draw reference model predicts
// results, fallback flags and the valid edge; a monitor checks each valid pulse.
module tb_rng_lfsr_bank;

  localparam int          NCH      = 4;
  localparam int          OUT_W    = 4;
  localparam int          MAX_TRY  = 3;
  localparam logic [31:0] POLY     = 32'h80200003;
  localparam logic [31:0] SEED_DEF = 32'd758932;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 seed_load;
  logic [31:0]          seed;
  logic                 req;
  logic [2:0]           mode;
  logic [OUT_W-1:0]     limit;
  logic                 busy;
  logic                 valid;
  logic [NCH*OUT_W-1:0] o;
  logic [NCH-1:0]       fallback;

  rng_lfsr_bank #(
    .NCH(NCH), .OUT_W(OUT_W), .POLY(POLY), .SEED_DEFAULT(SEED_DEF), .MAX_TRY(MAX_TRY)
  ) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
    .mode(mode), .limit(limit), .busy(busy), .valid(valid), .o(o), .fallback(fallback)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [NCH*OUT_W-1:0] o;
    logic [NCH-1:0]       fb;
    int                   due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ms [NCH];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_whiten(input logic [31:0] x, input int c);
    logic [31:0] cc;
    logic [31:0] v;
    cc = c;
    v  = x ^ (cc * 32'h9E3779B9);
    return (v == 32'h0) ? 32'h1 : v;
  endfunction

  function automatic logic [31:0] m_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  // Each channel independently: up to MAX_TRY rounds of mode+1 steps,
  // stop at the first candidate within the bound.
  task automatic model_draw(input int m, input int lim, output logic [NCH*OUT_W-1:0] ro,
                            output logic [NCH-1:0] rfb, output int rounds);
    rounds = 0;
    ro     = '0;
    rfb    = '0;
    for (int c = 0; c < NCH; c++) begin
      int  used;
      bit  got;
      int  cand;
      got  = 0;
      used = MAX_TRY;
      for (int t = 1; t <= MAX_TRY && !got; t++) begin
        for (int k = 0; k <= m; k++) ms[c] = m_step(ms[c]);
        cand = int'(ms[c] % (1 << OUT_W));
        if (lim == 0 || cand < lim) begin
          got  = 1;
          used = t;
          ro[c*OUT_W +: OUT_W] = OUT_W'(cand);
        end
      end
      if (!got) rfb[c] = 1'b1;
      if (used > rounds) rounds = used;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got valid=1 expected no pulse (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          chk("o", 32'(o), 32'(e.o));
          chk("fallback", 32'(fallback), 32'(e.fb));
          chk("valid_edge", 32'(edge_cnt), 32'(e.due));
          chk("busy_at_valid", 32'(busy), 32'h0);
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge where valid is seen.
  task automatic do_draw(input int m, input int lim, input bit noise);
    exp_t e;
    int   rounds;
    bit   got;
    req   = 1'b1;
    mode  = 3'(m);
    limit = OUT_W'(lim);
    model_draw(m, lim, e.o, e.fb, rounds);
    e.due = edge_cnt + 1 + rounds * (m + 2);
    q.push_back(e);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (valid) got = 1;
      else req = noise ? 1'($urandom % 2) : 1'b0;
    end
    req = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL draw_timeout: got no valid expected pulse by edge %0d", e.due);
      q.delete();
    end
  endtask

  task automatic load_seed(input logic [31:0] v);
    seed_load = 1'b1;
    seed      = v;
    @(negedge clk);
    seed_load = 1'b0;
    req       = 1'b0;
    for (int c = 0; c < NCH; c++) ms[c] = m_whiten(v, c);
    chk("seed_o", 32'(o), 32'h0);
    chk("seed_fallback", 32'(fallback), 32'h0);
    chk("seed_busy", 32'(busy), 32'h0);
    chk("seed_valid", 32'(valid), 32'h0);
  endtask

  initial begin
    rst = 1'b0; seed_load = 1'b0; seed = 32'h0; req = 1'b0; mode = 3'd0; limit = '0;
    for (int c = 0; c < NCH; c++) ms[c] = m_whiten(SEED_DEF, c);
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_o", 32'(o), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_fallback", 32'(fallback), 32'h0);

    do_draw(0, 0, 1'b0);
    do_draw(2, 9, 1'b0);

    load_seed(32'h1);
    do_draw(0, 0, 1'b0);
    load_seed(32'h1);
    do_draw(0, 3, 1'b0);
    load_seed(32'h1);
    do_draw(0, 1, 1'b0);

    // Abort a draw mid-STEP with a zero seed; the simultaneous req is dropped.
    @(negedge clk);
    req = 1'b1; mode = 3'd7; limit = '0;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    req = 1'b1;
    load_seed(32'h0);
    repeat (15) @(negedge clk);
    do_draw(0, 0, 1'b0);

    // Back-to-back full-range draws with stray req pulses while busy.
    for (int i = 0; i < 4; i++) do_draw(7, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      if ($urandom_range(0, 7) == 0) load_seed($urandom);
      do_draw($urandom_range(0, 7), $urandom_range(0, 15), 1'($urandom % 2));
    end

    repeat (20) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
